// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: default parameters,
// FSM state encoding and the registered memory command bundle.
package riscv_mem_pkg;

    localparam int DEF_TIMEOUT        = 64;
    localparam int DEF_MAX_DATA_BURST = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_cmd_t;

endpackage

// File: rtl/arb_watchdog.sv
// Counts cycles of an outstanding access and flags the cycle in which the
// TIMEOUT-th busy cycle is reached.
module arb_watchdog
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // The first busy cycle sees count==0, so TIMEOUT-1 marks the TIMEOUT-th cycle.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto one
// variable-latency memory, with bounded fetch starvation and an access timeout.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT        = DEF_TIMEOUT,
    parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        busy
);

    localparam int SW = $clog2(MAX_DATA_BURST + 1);

    logic [1:0]    state, state_next;
    logic [SW-1:0] starve_cnt;
    logic          starve_full;
    logic          grant_i, grant_d;
    logic          in_busy, expired, done, timed_out;
    mem_cmd_t      cmd;

    assign in_busy     = (state != ST_IDLE);
    assign starve_full = (starve_cnt == SW'(MAX_DATA_BURST));
    assign grant_d     = (state == ST_IDLE) && d_req && !(i_req && starve_full);
    assign grant_i     = (state == ST_IDLE) && i_req && !grant_d;
    assign done        = in_busy && (mem_ack || expired);
    assign timed_out   = expired && !mem_ack;

    always_comb begin
        // NOTE: default assignment first, so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_d)      state_next = ST_BUSY_D;
                else if (grant_i) state_next = ST_BUSY_I;
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments to avoid update-order races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            cmd     <= '0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                mem_req <= 1'b1;
                cmd     <= '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
            end else if (grant_i) begin
                mem_req <= 1'b1;
                cmd     <= '{we: 1'b0, addr: i_addr, wdata: 32'd0, wstrb: 4'd0};
            end else if (done) begin
                mem_req <= 1'b0;
            end
        end
    end

    // Data grants while fetch is waiting build up the count; it saturates at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_d && i_req) begin
            if (!starve_full) starve_cnt <= starve_cnt + SW'(1);
        end else if (grant_d || grant_i) begin
            starve_cnt <= '0;
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (grant_i || grant_d),
        .clear   (done),
        .enable  (in_busy),
        .expired (expired)
    );

    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_wstrb = cmd.wstrb;
    assign busy      = in_busy;

    // A mem_ack coinciding with expiry wins, so read data only passes on a real ack.
    assign i_ack   = (state == ST_BUSY_I) && done;
    assign i_err   = (state == ST_BUSY_I) && timed_out;
    assign i_rdata = ((state == ST_BUSY_I) && mem_ack) ? mem_rdata : 32'd0;

    assign d_ack   = (state == ST_BUSY_D) && done;
    assign d_err   = (state == ST_BUSY_D) && timed_out;
    assign d_rdata = ((state == ST_BUSY_D) && mem_ack) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// request/latency rounds checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TIMEOUT        = 64;
    localparam int MAX_DATA_BURST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy;
    logic [3:0]  mem_wstrb;

    int    checks   = 0;
    int    failures = 0;
    int    starve   = 0;
    string grant_log;

    mem_arbiter #(
        .TIMEOUT        (TIMEOUT),
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_acks"}, 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    // One arbitration round, entered just after a falling edge with the arbiter idle.
    // The model decides the winner from the fairness rule and predicts the completion
    // cycle as min(lat+1, TIMEOUT), counted in busy cycles.
    task automatic round(input logic ir, input logic dr, input int lat,
                         input logic [31:0] rd, output logic won_d);
        logic        exp_d, exp_err, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wstrb;
        int          k_done;

        i_req     = ir;
        d_req     = dr;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
        check_quiet("idle");
        won_d = 1'b0;
        if (!ir && !dr) begin
            @(negedge clk);
            return;
        end

        exp_d = dr && !(ir && starve == MAX_DATA_BURST);
        if (exp_d && ir) starve = (starve < MAX_DATA_BURST) ? starve + 1 : MAX_DATA_BURST;
        else             starve = 0;
        won_d     = exp_d;
        exp_addr  = exp_d ? d_addr  : i_addr;
        exp_we    = exp_d ? d_we    : 1'b0;
        exp_wdata = exp_d ? d_wdata : 32'd0;
        exp_wstrb = exp_d ? d_wstrb : 4'd0;
        k_done    = (lat + 1 < TIMEOUT) ? lat + 1 : TIMEOUT;
        exp_err   = (lat + 1 > TIMEOUT);

        for (int k = 1; k <= k_done; k++) begin
            @(negedge clk);
            mem_ack   = (k == lat + 1);
            mem_rdata = mem_ack ? rd : $urandom;
            #1;
            check("busy", 32'(busy), 32'd1);
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_addr", mem_addr, exp_addr);
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("mem_wdata", mem_wdata, exp_wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            if (k < k_done) begin
                check_quiet("wait");
            end else begin
                check("d_ack", 32'(d_ack), 32'(exp_d));
                check("i_ack", 32'(i_ack), 32'(!exp_d));
                check("d_err", 32'(d_err), 32'(exp_d && exp_err));
                check("i_err", 32'(i_err), 32'(!exp_d && exp_err));
                check("d_rdata", d_rdata, (exp_d && !exp_err) ? rd : 32'd0);
                check("i_rdata", i_rdata, (!exp_d && !exp_err) ? rd : 32'd0);
                grant_log = {grant_log, i_ack ? "I" : (d_ack ? "D" : "-")};
            end
        end

        @(negedge clk);
        mem_ack = 1'b0;
        if (exp_d) d_req = 1'b0;
        else       i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic won_d, ir, dr, i_held, d_held;

        reset = 1'b0;  i_req = 1'b0;  d_req = 1'b0;  d_we = 1'b0;  mem_ack = 1'b0;
        i_addr = '0;   d_addr = '0;   d_wdata = '0;  d_wstrb = '0;  mem_rdata = 32'hFFFF_FFFF;

        @(negedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_quiet("rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Data write with memory answering three cycles after mem_req rises.
        d_addr = 32'h0000_0100;  d_we = 1'b1;  d_wdata = 32'hDEAD_BEEF;  d_wstrb = 4'hF;
        round(1'b0, 1'b1, 3, 32'h1234_5678, won_d);

        // Fetch with the ack in the first mem_req cycle: ack one cycle after the request.
        i_addr = 32'h0000_0040;
        round(1'b1, 1'b0, 0, 32'h0050_0093, won_d);

        // No ack ever: timeout at the TIMEOUT-th busy cycle with err set.
        d_addr = 32'h0000_0200;  d_we = 1'b0;  d_wdata = 32'h0;  d_wstrb = 4'h0;
        round(1'b0, 1'b1, 1000, 32'hAAAA_5555, won_d);

        // Ack in the same cycle as expiry counts as a normal completion.
        i_addr = 32'h0000_0300;
        round(1'b1, 1'b0, TIMEOUT - 1, 32'hCAFE_F00D, won_d);

        // Both ports requesting continuously with immediate acks.
        grant_log = "";
        i_addr = 32'h0000_1000;  d_addr = 32'h0000_2000;  d_we = 1'b1;
        d_wdata = 32'h0BAD_F00D;  d_wstrb = 4'h3;
        for (int n = 0; n < 10; n++) round(1'b1, 1'b1, 0, $urandom, won_d);
        check_str("grant_order", grant_log, "DDDDIDDDDI");
        i_req = 1'b0;
        d_req = 1'b0;

        // Reset asserted mid-fetch abandons the access without an ack.
        i_addr = 32'h0000_0080;
        i_req  = 1'b1;
        #1;
        @(negedge clk);
        #1;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        reset   = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check_quiet("mid_rst");
        @(negedge clk);
        #1;
        check_quiet("held_rst");
        i_req  = 1'b0;
        reset  = 1'b1;
        starve = 0;
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        check("stray_ack_busy", 32'(busy), 32'd0);
        check_quiet("stray_ack");
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);

        // Random traffic; a losing requester keeps its request and fields unchanged.
        i_held = 1'b0;
        d_held = 1'b0;
        for (int n = 0; n < 60; n++) begin
            ir = i_held || ($urandom_range(0, 3) != 0);
            dr = d_held || ($urandom_range(0, 3) != 0);
            if (ir && !i_held) i_addr = $urandom;
            if (dr && !d_held) begin
                d_addr  = $urandom;
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(0, 15));
            end
            round(ir, dr, $urandom_range(0, 5), $urandom, won_d);
            i_held = ir && dr && won_d;
            d_held = ir && dr && !won_d;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum cycles a granted access waits for mem_ack before it is aborted.
REQ-002 SHALL have parameter MAX_DATA_BURST, default 4: maximum consecutive data grants while fetch waits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports i_req (in, 1), i_addr (in, 32), i_rdata (out, 32), i_ack (out, 1) and i_err (out, 1): the instruction-fetch requester port, which is read-only.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_wstrb (in, 4), d_rdata (out, 32), d_ack (out, 1) and d_err (out, 1): the data-access (MEM stage) requester port.
REQ-007 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_wstrb (out, 4), mem_rdata (in, 32) and mem_ack (in, 1): the shared single-port memory, which has variable latency.
REQ-008 SHALL have port busy, out, 1: high while an access is outstanding.

Function
REQ-009 SHALL use states IDLE, BUSY_I and BUSY_D.
REQ-010 SHALL, in IDLE, sample requests each cycle; with d_req only, the next state is BUSY_D; with i_req only, BUSY_I; with neither, remain in IDLE.
REQ-011 SHALL, when both requests are present in IDLE, grant data unless the starvation count equals MAX_DATA_BURST, in which case fetch is granted.
REQ-012 SHALL increment the starvation count on each data grant made while i_req=1, and clear it on a fetch grant or on a data grant made while i_req=0; the count saturates at MAX_DATA_BURST.
REQ-013 SHALL register mem_addr, mem_we, mem_wdata and mem_wstrb at grant from the granted port; a fetch grant drives mem_we=0 and mem_wstrb=0.
REQ-014 SHALL hold mem_req=1 from the cycle after grant through the mem_ack cycle inclusive, with mem_* request signals stable throughout.
REQ-015 SHALL, in the cycle mem_ack=1 in BUSY_x, pulse the owning port's ack for one cycle with x_rdata=mem_rdata (combinational passthrough); the next state is IDLE.
REQ-016 SHALL drive x_rdata=0 whenever x_ack=0, and SHALL never drive i_ack and d_ack high in the same cycle.
REQ-017 SHALL ignore mem_ack while in IDLE.
REQ-018 SHALL give a minimum latency of request-in-IDLE at cycle n to ack at cycle n+1, and a peak throughput of one access per 2 cycles.
REQ-019 SHALL count cycles in BUSY_x; if TIMEOUT cycles elapse with no mem_ack, then that cycle x_ack=1, x_err=1, x_rdata=0, mem_req=0 next cycle, and the next state is IDLE.
REQ-020 SHALL treat mem_ack in the same cycle as timeout expiry as a normal completion (err=0).
REQ-021 SHALL require requesters to hold req and request signals stable until ack; a new request may be presented the cycle after ack.
REQ-022 SHALL drive busy=1 in BUSY_I and BUSY_D, and busy=0 in IDLE.

Reset
REQ-023 SHALL, on reset=0 at any time (including mid-access), force IDLE, mem_req=0, mem_we=0, mem_addr/mem_wdata=0, mem_wstrb=0, all acks/errs=0, starvation and timeout counters=0.
REQ-024 SHALL abandon an in-flight access on reset without acknowledging it to the requester.

Structure
REQ-025 SHALL place the state enumeration and the TIMEOUT/MAX_DATA_BURST defaults in shared package riscv_mem_pkg.
REQ-026 SHALL implement the timeout counter as sub-module arb_watchdog (inputs start, clear, enable; output expired).

Verification
REQ-027 SHALL cover: d_req only, addr 0x100, we=1, wdata 0xDEADBEEF, wstrb 0xF, mem_ack 3 cycles after mem_req -> mem_* match, d_ack one pulse, d_err=0.
REQ-028 SHALL cover: i_req and d_req held continuously, mem_ack immediate -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-029 SHALL cover: i_req at addr 0x40, mem_rdata 0x00500093 with mem_ack in the first mem_req cycle -> i_ack at n+1 with i_rdata 0x00500093, mem_we=0.
REQ-030 SHALL cover: d_req, mem_ack never asserted -> d_ack=1 and d_err=1 exactly 64 cycles into BUSY_D, then IDLE.
REQ-031 SHALL cover: reset=0 asserted during BUSY_I -> mem_req=0 immediately, no i_ack, IDLE after release.
